// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device using the request-to-send sequence:
// hold the clock low, pull data low, then release the clock. After that the
// device clocks out data, odd parity and stop, and finally answers with an
// acknowledge bit. Both lines are only ever pulled low. The surrounding top level
// turns each *_oe into a pull-down (oe=1 -> 0, oe=0 -> z).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   tx_data      command byte to send
//   tx_valid     request to send tx_data
//   tx_ready     high while idle; byte accepted on tx_valid & tx_ready
//   busy         high in every state except IDLE; receive path ignores the lines
//   tx_done      one-cycle pulse: byte sent and acknowledged
//   tx_error     one-cycle pulse: device nack or timeout
//   ps2_clk_in   raw ps2_clk line level
//   ps2_data_in  raw ps2_data line level
//   ps2_clk_oe   1 = pull ps2_clk low
//   ps2_data_oe  1 = pull ps2_data low

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t state;

    // Line synchronizers and falling-edge detector. Idle lines are high, so
    // the synchronizer resets to 1 to avoid a false edge after reset.
    logic clk_meta;
    logic clk_sync;
    logic clk_prev;
    logic data_meta;
    logic data_sync;
    logic fe;

    logic [7:0]       shreg;
    logic             parity;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             nack;
    logic [9:0]       frame;

    // Bit order on the wire after the start bit: data LSB first, parity, stop.
    assign frame = {1'b1, parity, shreg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            fe        <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
            fe        <= clk_prev & ~clk_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            shreg       <= 8'h00;
            parity      <= 1'b0;
            bit_cnt     <= 4'd0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            nack        <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    // tx_ready is low in the done/error pulse cycle and comes
                    // back one cycle later, so a held tx_valid cannot re-accept
                    // in the same cycle the previous result is reported.
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
                        parity     <= ~^tx_data;
                        bit_cnt    <= 4'd0;
                        inh_cnt    <= '0;
                        nack       <= 1'b0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end

                REQ: begin
                    // Clock released with data still low: that is the start bit.
                    ps2_clk_oe <= 1'b0;
                    tmo_cnt    <= '0;
                    bit_cnt    <= 4'd0;
                    state      <= SHIFT;
                end

                SHIFT, ACK: begin
                    if (tmo_cnt == TMO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (fe) begin
                            if (state == SHIFT) begin
                                ps2_data_oe <= ~frame[bit_cnt];
                                if (bit_cnt == 4'd9) begin
                                    state <= ACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end else begin
                                // Device pulls data low to acknowledge.
                                nack  <= data_sync;
                                state <= WAIT_IDLE;
                            end
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        tx_done  <= ~nack;
                        tx_error <= nack;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TMO  = 3000;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    // Wired-AND of host and device pull-downs with an external pull-up.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int done_seen = 0;
    int err_seen = 0;
    int accepts = 0;
    int ready_busy = 0;

    typedef struct {
        logic [9:0] frame;
        logic       err;
    } exp_t;

    exp_t sb[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_seen <= done_seen + 1;
        if (tx_error) err_seen <= err_seen + 1;
        if (tx_valid && tx_ready) accepts <= accepts + 1;
    end

    always @(negedge clk) begin
        if (busy && tx_ready) ready_busy <= ready_busy + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, input logic nack_exp, input bit hold);
        exp_t e;
        int   n;
        e.frame = {1'b1, ~^d, d};
        e.err   = nack_exp;
        sb.push_back(e);
        @(negedge clk);
        check("ready_before", 32'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        check("busy_after_accept", 32'({tx_ready, busy}), 32'b01);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("req_len", n, 1);
        check("shift_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    endtask

    task automatic device(input bit do_ack);
        logic [9:0] got;
        got = '0;
        check("start_bit", 32'(ps2_data_in), 0);
        for (int i = 0; i < 10; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            got[i] = ps2_data_in;
        end
        if (sb.size() > 0) check("frame", 32'(got), 32'(sb[0].frame));
        repeat (HALF) @(negedge clk);
        dev_data_low = do_ack;
        dev_clk_low  = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_result();
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (!tx_done && !tx_error && n < 200) begin
            n++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("result", 32'({tx_done, tx_error}), e.err ? 32'b01 : 32'b10);
        check("lines_released", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'b000);
        @(negedge clk);
        check("ready_after", 32'({tx_ready, tx_done, tx_error}), 32'b100);
    endtask

    initial begin
        int t0;
        int n;
        int a0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(tx_ready), 1);

        start_tx(8'hF4, 1'b0, 1'b0);
        device(1'b1);
        wait_result();
        start_tx(8'h00, 1'b0, 1'b0);
        device(1'b1);
        wait_result();
        start_tx(8'hFF, 1'b0, 1'b0);
        device(1'b1);
        wait_result();
        check("done_count_acks", done_seen, 3);
        check("err_count_acks", err_seen, 0);

        start_tx(8'hF4, 1'b1, 1'b0);
        device(1'b0);
        wait_result();
        check("done_count_nack", done_seen, 3);
        check("err_count_nack", err_seen, 1);

        start_tx(8'hE6, 1'b1, 1'b0);
        t0 = cyc;
        n = 0;
        while (!tx_error && n < TMO + 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", cyc - t0, TMO);
        check("timeout_lines", 32'({tx_error, ps2_clk_oe, ps2_data_oe, tx_done}), 32'b1000);
        void'(sb.pop_front());
        @(negedge clk);
        check("ready_after_timeout", 32'({tx_ready, tx_error}), 32'b10);

        start_tx(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        check("mid_frame_data_oe", 32'({ps2_data_oe, busy}), 32'b11);
        #3 reset = 1'b1;
        #1;
        check("async_reset", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_ready}), 0);
        void'(sb.pop_front());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_tx(8'hFF, 1'b0, 1'b0);
        device(1'b1);
        wait_result();

        a0 = accepts;
        start_tx(8'h5A, 1'b0, 1'b1);
        device(1'b1);
        wait_result();
        repeat (3) @(negedge clk);
        check("one_accept_held_valid", accepts - a0, 1);
        check("ready_while_busy", ready_busy, 0);
        check("done_total", done_seen, 5);
        check("err_total", err_seen, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
